// File: rtl/regfile_pkg.sv
// Shared types and constants for the writeback stage: register indices, opcode decode values, WB pipeline entry.
// Pure declarations plus a CMP decode helper; no state.
package regfile_pkg;

  localparam int NUM_REGS  = 16;
  localparam int DATA_W    = 64;
  localparam int CNT_W     = 2;
  localparam int REG_IDX_W = 4;
  localparam logic [DATA_W-1:0] RSP_RESET = 64'h0000_0000_0001_0000;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_RAX = 4'd0;
  localparam reg_idx_t REG_RDX = 4'd2;
  localparam reg_idx_t REG_RSP = 4'd4;

  localparam logic [7:0] OP_CMP_39  = 8'h39;
  localparam logic [7:0] OP_CMP_3B  = 8'h3B;
  localparam logic [7:0] OP_CMP_3D  = 8'h3D;
  localparam logic [7:0] OP_GRP1_81 = 8'h81;
  localparam logic [7:0] OP_GRP1_83 = 8'h83;
  localparam logic [2:0] EXT_CMP    = 3'b111;

  typedef struct packed {
    logic [7:0]        opcode;
    logic [31:0]       opcode_len;
    logic [31:0]       has_ext;
    logic [2:0]        ext_op;
    reg_idx_t          dest;
    reg_idx_t          dest_sp;
    logic              dest_sp_vld;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] result_sp;
  } wb_entry_t;

  // Two-byte opcodes (0F xx) reuse these byte values for unrelated instructions, so only length-1 forms are CMP.
  function automatic logic is_cmp(input wb_entry_t e);
    logic one_byte;
    logic plain_cmp;
    logic grp1_cmp;
    one_byte  = (e.opcode_len == 32'd1);
    plain_cmp = (e.opcode == OP_CMP_39) || (e.opcode == OP_CMP_3B) || (e.opcode == OP_CMP_3D);
    grp1_cmp  = ((e.opcode == OP_GRP1_81) || (e.opcode == OP_GRP1_83)) &&
                (e.has_ext != 32'd0) && (e.ext_op == EXT_CMP);
    return one_byte && (plain_cmp || grp1_cmp);
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy counters: reserve at issue, release at commit, all-or-nothing stall on counter overflow.
// Stall and busy are combinational from current counts; counts update on the next edge.
module wb_scoreboard
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rsv_vld,
  input  reg_idx_t rsv_dest,
  input  reg_idx_t rsv_dest_sp,
  input  logic     rsv_dest_sp_vld,
  input  logic     rel_vld,
  input  reg_idx_t rel_dest,
  input  reg_idx_t rel_dest_sp,
  input  logic     rel_dest_sp_vld,
  input  reg_idx_t rd_addr_a,
  input  reg_idx_t rd_addr_b,
  output logic     busy_a,
  output logic     busy_b,
  output logic     stall
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] cnt     [NUM_REGS];
  logic [CNT_W-1:0] cnt_nxt [NUM_REGS];
  logic [SUM_W-1:0] inc     [NUM_REGS];
  logic [SUM_W-1:0] dec     [NUM_REGS];
  logic [SUM_W-1:0] sum     [NUM_REGS];
  logic [NUM_REGS-1:0] over;

  // Both destinations may name the same register, so each side contributes 0..2 per counter.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      inc[i]  = SUM_W'(rsv_vld && (rsv_dest == reg_idx_t'(i))) +
                SUM_W'(rsv_vld && rsv_dest_sp_vld && (rsv_dest_sp == reg_idx_t'(i)));
      dec[i]  = SUM_W'(rel_vld && (rel_dest == reg_idx_t'(i))) +
                SUM_W'(rel_vld && rel_dest_sp_vld && (rel_dest_sp == reg_idx_t'(i)));
      over[i] = ({2'b00, cnt[i]} + inc[i]) > (CNT_MAX + dec[i]);
    end
  end

  assign stall = |over;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      sum[i]     = {2'b00, cnt[i]} + (stall ? SUM_W'(0) : inc[i]);
      cnt_nxt[i] = (sum[i] > dec[i]) ? CNT_W'(sum[i] - dec[i]) : '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!rst_n) begin
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign busy_a = |cnt[rd_addr_a];
  assign busy_b = |cnt[rd_addr_b];

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: registers execute results, commits them one cycle later into a 16x64 regfile with read bypass.
// One result accepted per cycle, never back-pressured; issue stalls only on busy-counter overflow.
module writeback_regfile
  import regfile_pkg::*;
#(
  parameter logic [DATA_W-1:0] RSP_INIT = RSP_RESET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exValidIn,
  input  logic [7:0]        opcodeIn,
  input  logic [31:0]       opcodeLengthIn,
  input  logic [31:0]       hasExtendedOpcodeIn,
  input  logic [2:0]        extendedOpcodeIn,
  input  logic [3:0]        destRegIn,
  input  logic [3:0]        destRegSpecialIn,
  input  logic              destRegSpecialValidIn,
  input  logic [DATA_W-1:0] aluResultIn,
  input  logic [DATA_W-1:0] aluResultSpecialIn,
  input  logic [3:0]        rdAddrA,
  input  logic [3:0]        rdAddrB,
  output logic [DATA_W-1:0] rdDataA,
  output logic [DATA_W-1:0] rdDataB,
  output logic              rdBusyA,
  output logic              rdBusyB,
  input  logic              issueValidIn,
  input  logic [3:0]        issueDestIn,
  input  logic [3:0]        issueDestSpecialIn,
  input  logic              issueDestSpecialValidIn,
  output logic              issueStallOut,
  output logic [63:0]       retiredCountOut
);

  wb_entry_t         ex_d;
  wb_entry_t         wb_q;
  logic              wb_vld;
  logic              commit;
  logic              prim_we;
  logic              sp_we;
  logic [DATA_W-1:0] regs    [NUM_REGS];
  reg_idx_t          rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic [63:0]       retired;

  always_comb begin
    ex_d             = '0;
    ex_d.opcode      = opcodeIn;
    ex_d.opcode_len  = opcodeLengthIn;
    ex_d.has_ext     = hasExtendedOpcodeIn;
    ex_d.ext_op      = extendedOpcodeIn;
    ex_d.dest        = destRegIn;
    ex_d.dest_sp     = destRegSpecialIn;
    ex_d.dest_sp_vld = destRegSpecialValidIn;
    ex_d.result      = aluResultIn;
    ex_d.result_sp   = aluResultSpecialIn;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_vld <= 1'b0;
      wb_q   <= '0;
    end else begin
      wb_vld <= exValidIn;
      wb_q   <= ex_d;
    end
  end

  // Reset low kills the in-flight entry: no write, no release, no retire, no bypass.
  assign commit  = reset && wb_vld;
  assign prim_we = commit && !is_cmp(wb_q);
  assign sp_we   = commit && wb_q.dest_sp_vld;

  // Secondary write is issued last so it wins when both destinations coincide.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == int'(REG_RSP)) ? RSP_INIT : '0;
      end
    end else begin
      if (prim_we) regs[wb_q.dest]    <= wb_q.result;
      if (sp_we)   regs[wb_q.dest_sp] <= wb_q.result_sp;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      retired <= '0;
    end else if (commit) begin
      retired <= retired + 64'd1;
    end
  end

  assign rd_addr[0] = rdAddrA;
  assign rd_addr[1] = rdAddrB;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs[rd_addr[p]];
      if (prim_we && (wb_q.dest == rd_addr[p]))  rd_data[p] = wb_q.result;
      if (sp_we && (wb_q.dest_sp == rd_addr[p])) rd_data[p] = wb_q.result_sp;
    end
  end

  assign rdDataA         = rd_data[0];
  assign rdDataB         = rd_data[1];
  assign retiredCountOut = retired;

  wb_scoreboard u_scoreboard (
    .clk             (clk),
    .rst_n           (reset),
    .rsv_vld         (issueValidIn),
    .rsv_dest        (issueDestIn),
    .rsv_dest_sp     (issueDestSpecialIn),
    .rsv_dest_sp_vld (issueDestSpecialValidIn),
    .rel_vld         (commit),
    .rel_dest        (wb_q.dest),
    .rel_dest_sp     (wb_q.dest_sp),
    .rel_dest_sp_vld (wb_q.dest_sp_vld),
    .rd_addr_a       (rdAddrA),
    .rd_addr_b       (rdAddrB),
    .busy_a          (rdBusyA),
    .busy_b          (rdBusyB),
    .stall           (issueStallOut)
  );

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: directed scenarios then randomized traffic against an array-based model.
module tb_writeback_regfile;

  localparam logic [63:0] RSP_VAL = 64'h0000_0000_0001_0000;

  logic        clk;
  logic        reset;
  logic        exValidIn;
  logic [7:0]  opcodeIn;
  logic [31:0] opcodeLengthIn;
  logic [31:0] hasExtendedOpcodeIn;
  logic [2:0]  extendedOpcodeIn;
  logic [3:0]  destRegIn;
  logic [3:0]  destRegSpecialIn;
  logic        destRegSpecialValidIn;
  logic [63:0] aluResultIn;
  logic [63:0] aluResultSpecialIn;
  logic [3:0]  rdAddrA;
  logic [3:0]  rdAddrB;
  logic [63:0] rdDataA;
  logic [63:0] rdDataB;
  logic        rdBusyA;
  logic        rdBusyB;
  logic        issueValidIn;
  logic [3:0]  issueDestIn;
  logic [3:0]  issueDestSpecialIn;
  logic        issueDestSpecialValidIn;
  logic        issueStallOut;
  logic [63:0] retiredCountOut;

  writeback_regfile dut (
    .clk                     (clk),
    .reset                   (reset),
    .exValidIn               (exValidIn),
    .opcodeIn                (opcodeIn),
    .opcodeLengthIn          (opcodeLengthIn),
    .hasExtendedOpcodeIn     (hasExtendedOpcodeIn),
    .extendedOpcodeIn        (extendedOpcodeIn),
    .destRegIn               (destRegIn),
    .destRegSpecialIn        (destRegSpecialIn),
    .destRegSpecialValidIn   (destRegSpecialValidIn),
    .aluResultIn             (aluResultIn),
    .aluResultSpecialIn      (aluResultSpecialIn),
    .rdAddrA                 (rdAddrA),
    .rdAddrB                 (rdAddrB),
    .rdDataA                 (rdDataA),
    .rdDataB                 (rdDataB),
    .rdBusyA                 (rdBusyA),
    .rdBusyB                 (rdBusyB),
    .issueValidIn            (issueValidIn),
    .issueDestIn             (issueDestIn),
    .issueDestSpecialIn      (issueDestSpecialIn),
    .issueDestSpecialValidIn (issueDestSpecialValidIn),
    .issueStallOut           (issueStallOut),
    .retiredCountOut         (retiredCountOut)
  );

  typedef struct {
    bit          rst_n;
    bit          ex;
    logic [7:0]  op;
    logic [31:0] len;
    logic [31:0] hx;
    logic [2:0]  ext;
    logic [3:0]  dest;
    logic [3:0]  dsp;
    bit          spv;
    logic [63:0] res;
    logic [63:0] ressp;
    logic [3:0]  ra;
    logic [3:0]  rb;
    bit          iv;
    logic [3:0]  id;
    logic [3:0]  ids;
    bit          isv;
  } stim_t;

  typedef struct {
    bit          vld;
    bit          cmp;
    logic [3:0]  dest;
    logic [3:0]  dsp;
    bit          spv;
    logic [63:0] res;
    logic [63:0] ressp;
  } pend_t;

  typedef struct {
    logic [63:0] da;
    logic [63:0] db;
    bit          ba;
    bit          bb;
    bit          st;
    logic [63:0] ret;
  } exp_t;

  logic [63:0] m_regs [16];
  int          m_busy [16];
  logic [63:0] m_ret;
  pend_t       pend;
  exp_t        exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "simulation did not complete");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic bit model_cmp(input stim_t s);
    if (s.len != 32'd1) return 1'b0;
    if (s.op == 8'h39 || s.op == 8'h3B || s.op == 8'h3D) return 1'b1;
    return (s.op == 8'h81 || s.op == 8'h83) && (s.hx != 32'd0) && (s.ext == 3'd7);
  endfunction

  // A reservation fails if the register would hold more than 3 outstanding writes after this cycle's releases.
  function automatic bit model_stall(input stim_t s);
    if (!s.iv) return 1'b0;
    for (int i = 0; i < 16; i++) begin
      int need = m_busy[i];
      if (s.id == i) need++;
      if (s.isv && s.ids == i) need++;
      if (s.rst_n && pend.vld) begin
        if (pend.dest == i) need--;
        if (pend.spv && pend.dsp == i) need--;
      end
      if (need > 3) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [63:0] model_read(input logic [3:0] a, input bit rst_n);
    logic [63:0] v = m_regs[a];
    if (rst_n && pend.vld) begin
      if (!pend.cmp && pend.dest == a) v = pend.res;
      if (pend.spv && pend.dsp == a) v = pend.ressp;
    end
    return v;
  endfunction

  task automatic model_edge(input stim_t s);
    int nb [16];
    bit st;
    if (!s.rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[i] = (i == 4) ? RSP_VAL : 64'd0;
        m_busy[i] = 0;
      end
      m_ret    = 64'd0;
      pend.vld = 1'b0;
      return;
    end
    st = model_stall(s);
    for (int i = 0; i < 16; i++) nb[i] = m_busy[i];
    if (s.iv && !st) begin
      nb[s.id]++;
      if (s.isv) nb[s.ids]++;
    end
    if (pend.vld) begin
      nb[pend.dest]--;
      if (pend.spv) nb[pend.dsp]--;
      if (!pend.cmp) m_regs[pend.dest] = pend.res;
      if (pend.spv) m_regs[pend.dsp] = pend.ressp;
      m_ret = m_ret + 64'd1;
    end
    for (int i = 0; i < 16; i++) m_busy[i] = (nb[i] < 0) ? 0 : nb[i];
    pend.vld   = s.ex;
    pend.cmp   = model_cmp(s);
    pend.dest  = s.dest;
    pend.dsp   = s.dsp;
    pend.spv   = s.spv;
    pend.res   = s.res;
    pend.ressp = s.ressp;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst_n: 1'b1, ex: 1'b0, op: 8'h00, len: 32'd1, hx: 32'd0, ext: 3'd0, dest: 4'd0, dsp: 4'd0,
          spv: 1'b0, res: 64'd0, ressp: 64'd0, ra: 4'd4, rb: 4'd0, iv: 1'b0, id: 4'd0, ids: 4'd0, isv: 1'b0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    reset                   = s.rst_n;
    exValidIn               = s.ex;
    opcodeIn                = s.op;
    opcodeLengthIn          = s.len;
    hasExtendedOpcodeIn     = s.hx;
    extendedOpcodeIn        = s.ext;
    destRegIn               = s.dest;
    destRegSpecialIn        = s.dsp;
    destRegSpecialValidIn   = s.spv;
    aluResultIn             = s.res;
    aluResultSpecialIn      = s.ressp;
    rdAddrA                 = s.ra;
    rdAddrB                 = s.rb;
    issueValidIn            = s.iv;
    issueDestIn             = s.id;
    issueDestSpecialIn      = s.ids;
    issueDestSpecialValidIn = s.isv;
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    drive(s);
    e.da  = model_read(s.ra, s.rst_n);
    e.db  = model_read(s.rb, s.rst_n);
    e.ba  = (m_busy[s.ra] != 0);
    e.bb  = (m_busy[s.rb] != 0);
    e.st  = model_stall(s);
    e.ret = m_ret;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    model_edge(s);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rdDataA", rdDataA, e.da);
        chk("rdDataB", rdDataB, e.db);
        chk("rdBusyA", 64'(rdBusyA), 64'(e.ba));
        chk("rdBusyB", 64'(rdBusyB), 64'(e.bb));
        chk("issueStallOut", 64'(issueStallOut), 64'(e.st));
        chk("retiredCountOut", retiredCountOut, e.ret);
      end
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst_n = 1'b0;
    drive(s);
    repeat (2) @(posedge clk);
    #1;
    model_edge(s);

    // reset values
    for (int r = 0; r < 4; r++) begin
      s = idle(); s.rb = 4'(r); step(s);
    end

    // ADD to reg3: bypass next cycle, registered the cycle after
    s = idle(); s.iv = 1; s.id = 3; s.ra = 3; step(s);
    s = idle(); s.ex = 1; s.op = 8'h01; s.dest = 3; s.res = 64'h1234; s.ra = 3; s.rb = 3; step(s);
    s = idle(); s.ra = 3; s.rb = 3; step(s); step(s);

    // MUL F7 /4 with RDX secondary
    s = idle(); s.iv = 1; s.id = 0; s.ids = 2; s.isv = 1; s.ra = 0; s.rb = 2; step(s);
    s = idle(); s.ex = 1; s.op = 8'hF7; s.hx = 1; s.ext = 4; s.dest = 0; s.res = 64'd5;
    s.dsp = 2; s.spv = 1; s.ressp = 64'd7; s.ra = 0; s.rb = 2; step(s);
    s = idle(); s.ra = 0; s.rb = 2; step(s); step(s);

    // secondary wins when both destinations match
    s = idle(); s.ex = 1; s.op = 8'hF7; s.hx = 1; s.ext = 5; s.dest = 8; s.res = 64'hAA;
    s.dsp = 8; s.spv = 1; s.ressp = 64'hBB; s.ra = 8; step(s);
    s = idle(); s.ra = 8; step(s); step(s);

    // CMP 3B leaves reg1 intact but releases it
    s = idle(); s.ex = 1; s.op = 8'h01; s.dest = 1; s.res = 64'd9; s.ra = 1; step(s);
    s = idle(); s.iv = 1; s.id = 1; s.ra = 1; step(s);
    s = idle(); s.ex = 1; s.op = 8'h3B; s.dest = 1; s.res = 64'd0; s.ra = 1; s.rb = 1; step(s);
    s = idle(); s.ra = 1; s.rb = 1; step(s); step(s);

    // counter saturation on reg5, then reserve alongside a release
    for (int k = 0; k < 4; k++) begin
      s = idle(); s.iv = 1; s.id = 5; s.ra = 5; step(s);
    end
    s = idle(); s.ex = 1; s.op = 8'h01; s.dest = 5; s.res = 64'h55; s.ra = 5; step(s);
    s = idle(); s.iv = 1; s.id = 5; s.ra = 5; step(s);
    s = idle(); s.ra = 5; step(s);

    // double reservation of one register: +2 then overflow
    for (int k = 0; k < 2; k++) begin
      s = idle(); s.iv = 1; s.id = 7; s.ids = 7; s.isv = 1; s.ra = 7; step(s);
    end

    // reset while an entry for reg6 is in flight
    s = idle(); s.ex = 1; s.op = 8'h01; s.dest = 6; s.res = 64'hFF; s.ra = 6; step(s);
    s = idle(); s.rst_n = 0; s.ra = 6; s.rb = 5; step(s);
    s = idle(); s.ra = 6; s.rb = 5; step(s); step(s);

    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.rst_n = ($urandom_range(0, 63) != 0);
      s.ex    = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0: s.op = 8'h01;
        1: s.op = 8'h29;
        2: s.op = 8'h39;
        3: s.op = 8'h3B;
        4: s.op = 8'h3D;
        5: s.op = 8'h81;
        6: s.op = 8'h83;
        7: s.op = 8'hF7;
        8: s.op = 8'h89;
        default: s.op = 8'($urandom);
      endcase
      s.len   = ($urandom_range(0, 7) == 0) ? 32'd2 : 32'd1;
      s.hx    = 32'($urandom_range(0, 1));
      s.ext   = 3'($urandom_range(0, 7));
      s.dest  = 4'($urandom_range(0, 7));
      s.dsp   = 4'($urandom_range(0, 7));
      s.spv   = ($urandom_range(0, 2) == 0);
      s.res   = {$urandom, $urandom};
      s.ressp = {$urandom, $urandom};
      s.ra    = 4'($urandom_range(0, 15));
      s.rb    = 4'($urandom_range(0, 7));
      s.iv    = s.rst_n && ($urandom_range(0, 1) == 1);
      s.id    = 4'($urandom_range(0, 7));
      s.ids   = 4'($urandom_range(0, 7));
      s.isv   = ($urandom_range(0, 2) == 0);
      step(s);
    end

    s = idle();
    drive(s);
    repeat (2) @(negedge clk);
    chk("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
